// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU request arbiter
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int REQ_ID_W = 1;
    localparam int LAT_W    = 4;
    localparam int STAT_W   = 16;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// rtl/alu_req_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0]          valid,
    input  logic [REQ_ID_W-1:0] last_grant,
    output logic [1:0]          grant,
    output logic [REQ_ID_W-1:0] id
);

    always_comb begin
        grant = 2'b00;
        id    = '0;
        case (valid)
            2'b01: begin
                grant = 2'b01;
                id    = 1'b0;
            end
            2'b10: begin
                grant = 2'b10;
                id    = 1'b1;
            end
            2'b11: begin
                // Tie goes to whichever requester was not served last.
                if (last_grant == 1'b1) begin
                    grant = 2'b01;
                    id    = 1'b0;
                end else begin
                    grant = 2'b10;
                    id    = 1'b1;
                end
            end
            default: begin
                grant = 2'b00;
                id    = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-requester arbiter for the shared 8-bit datapath
// Optional grant counters enabled with `ALU_ARB_STATS_EN.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             dp_start,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(DP_LAT);

    state_t              state;
    logic [LAT_W-1:0]    lat_cnt;
    logic [REQ_ID_W-1:0] last_grant;
    logic [REQ_ID_W-1:0] cur_id;
    logic [REQ_ID_W-1:0] win_id;
    logic [1:0]          win;
    logic                idle;
    logic                take;

    rr_arb2 u_pick (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (win),
        .id         (win_id)
    );

    assign idle = (state == ST_IDLE);
    assign take = idle && (|win);
    assign busy = (state != ST_IDLE);

    // Ready is combinational; it is masked by reset so every output reads 0 while rst_n is low.
    assign req0_ready = idle && rst_n && win[0];
    assign req1_ready = idle && rst_n && win[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            last_grant <= 1'b1;
            cur_id     <= '0;
            dp_start   <= 1'b0;
            dp_a       <= '0;
            dp_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            dp_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        dp_a       <= win[1] ? req1_a : req0_a;
                        dp_b       <= win[1] ? req1_b : req0_b;
                        dp_start   <= 1'b1;
                        cur_id     <= win_id;
                        last_grant <= win_id;
                        lat_cnt    <= LAT_INIT;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        rsp_data  <= dp_y;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (take) begin
            if (win[0]) grant_cnt0 <= sat_inc(grant_cnt0);
            if (win[1]) grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       dp_start, rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] dp_a, dp_b, dp_y, rsp_data;

    logic       t_req0_valid, t_req1_valid, t_req0_ready, t_req1_ready;
    logic [7:0] t_req0_a, t_req0_b, t_req1_a, t_req1_b;
    logic       t_dp_start, t_rsp_valid, t_rsp_ready, t_rsp_id, t_busy;
    logic [7:0] t_dp_a, t_dp_b, t_dp_y, t_rsp_data;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, t_grant_cnt0, t_grant_cnt1;
`endif

    assign dp_y   = dp_a + dp_b;
    assign t_dp_y = t_dp_a + t_dp_b;

    int checks = 0;
    int errors = 0;

    alu_req_arbiter #(.WIDTH(8), .DP_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_y(dp_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    alu_req_arbiter #(.WIDTH(8), .DP_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(t_req0_valid), .req0_a(t_req0_a), .req0_b(t_req0_b), .req0_ready(t_req0_ready),
        .req1_valid(t_req1_valid), .req1_a(t_req1_a), .req1_b(t_req1_b), .req1_ready(t_req1_ready),
        .dp_start(t_dp_start), .dp_a(t_dp_a), .dp_b(t_dp_b), .dp_y(t_dp_y),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id), .rsp_data(t_rsp_data),
        .busy(t_busy)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(t_grant_cnt0), .grant_cnt1(t_grant_cnt1)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        t_req0_valid = 1'b0; t_req1_valid = 1'b0;
        t_req0_a = '0; t_req0_b = '0; t_req1_a = '0; t_req1_b = '0;
        rsp_ready = 1'b1; t_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (dp_start !== 1'b0) begin errors++; $display("FAIL reset_dp_start: got %b want 0", dp_start); end
        checks++;
        if ({dp_a, dp_b, rsp_data, rsp_id} !== 25'd0)
            begin errors++; $display("FAIL reset_data: dp_a=%h dp_b=%h rsp_data=%h rsp_id=%b want all 0", dp_a, dp_b, rsp_data, rsp_id); end
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_single;
        req0_a = 8'h12; req0_b = 8'h34; req0_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin errors++; $display("FAIL single_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        step;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dp_start !== 1'b1 || dp_a !== 8'h12 || dp_b !== 8'h34 || rsp_valid !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL single_issue: got start=%b a=%h b=%h rv=%b busy=%b want 1 12 34 0 1", dp_start, dp_a, dp_b, rsp_valid, busy); end
        step;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h46 || rsp_id !== 1'b0 || dp_start !== 1'b0)
            begin errors++; $display("FAIL single_rsp: got rv=%b data=%h id=%b start=%b want 1 46 0 0", rsp_valid, rsp_data, rsp_id, dp_start); end
        step;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL single_done: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
        step;
    endtask

    task automatic test_round_robin;
        int   got;
        logic dbl;
        logic seen;
        logic exp_id;
        apply_reset;
        req0_a = 8'h01; req0_b = 8'h02; req1_a = 8'h10; req1_b = 8'h20;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id = (i % 2 == 1);
            got = -1; dbl = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = req1_ready ? 1 : 0;
                    dbl = req0_ready && req1_ready;
                    break;
                end
                step;
            end
            checks++;
            if (got != int'(exp_id)) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, got, exp_id); end
            checks++;
            if (dbl) begin errors++; $display("FAIL rr_double[%0d]: got both ready want one", i); end
            step;
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (rsp_valid) begin seen = 1'b1; break; end
                step;
            end
            checks++;
            if (!seen || rsp_id !== exp_id || rsp_data !== (exp_id ? 8'h30 : 8'h03))
                begin errors++; $display("FAIL rr_rsp[%0d]: got seen=%b id=%b data=%h want 1 %b %h", i, seen, rsp_id, rsp_data, exp_id, exp_id ? 8'h30 : 8'h03); end
            step;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step;
    endtask

    task automatic test_hold_resp;
        logic seen;
        req0_a = 8'hFF; req0_b = 8'h02; req0_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_accept: got %b want 1", req0_ready); end
        step;
        req0_valid = 1'b0;
        req1_a = 8'h55; req1_b = 8'h11; req1_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
            step;
        end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (!seen || rsp_valid !== 1'b1 || rsp_data !== 8'h01 || rsp_id !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL hold_cycle[%0d]: got rv=%b data=%h id=%b r1=%b busy=%b want 1 01 0 0 1", j, rsp_valid, rsp_data, rsp_id, req1_ready, busy); end
            step;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0 || rsp_valid !== 1'b1)
            begin errors++; $display("FAIL hold_no_early_ready: got r1=%b rv=%b want 0 1", req1_ready, rsp_valid); end
        step;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL hold_next_ready: got r1=%b rv=%b want 1 0", req1_ready, rsp_valid); end
        step;
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
            step;
        end
        checks++;
        if (!seen || rsp_id !== 1'b1 || rsp_data !== 8'h66)
            begin errors++; $display("FAIL hold_req1_rsp: got seen=%b id=%b data=%h want 1 1 66", seen, rsp_id, rsp_data); end
        step;
    endtask

    task automatic test_reset_mid;
        logic seen;
        req1_a = 8'h07; req1_b = 8'h08; req1_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b want 1", req1_ready); end
        step;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dp_start, busy, rsp_valid, rsp_id, req0_ready, req1_ready} !== 6'd0 || {dp_a, dp_b, rsp_data} !== 24'd0)
            begin errors++; $display("FAIL mid_reset_outputs: start=%b busy=%b rv=%b a=%h b=%h data=%h want all 0", dp_start, busy, rsp_valid, dp_a, dp_b, rsp_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
            step;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_dropped: got activity=1 want 0 after reset"); end
        req0_a = 8'h03; req0_b = 8'h04; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin errors++; $display("FAIL mid_tie: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
        step;
        req0_valid = 1'b0; req1_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
            step;
        end
        checks++;
        if (!seen || rsp_id !== 1'b0 || rsp_data !== 8'h07)
            begin errors++; $display("FAIL mid_after_rsp: got seen=%b id=%b data=%h want 1 0 07", seen, rsp_id, rsp_data); end
        step;
    endtask

    task automatic test_lat3;
        logic exp_v;
        t_req0_a = 8'h10; t_req0_b = 8'h20; t_req0_valid = 1'b1; t_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (t_req0_ready !== 1'b1) begin errors++; $display("FAIL lat3_accept: got %b want 1", t_req0_ready); end
        step;
        t_req0_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_v = (k == 4);
            checks++;
            if (t_rsp_valid !== exp_v) begin errors++; $display("FAIL lat3_rsp_valid[%0d]: got %b want %b", k, t_rsp_valid, exp_v); end
            if (k == 1) begin
                checks++;
                if (t_dp_start !== 1'b1) begin errors++; $display("FAIL lat3_start: got %b want 1", t_dp_start); end
            end
            if (k == 4) begin
                checks++;
                if (t_rsp_data !== 8'h30) begin errors++; $display("FAIL lat3_data: got %h want 30", t_rsp_data); end
            end
            step;
        end
        step;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats;
        apply_reset;
        req1_a = 8'h01; req1_b = 8'h01;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (req1_ready) break;
                step;
            end
            step;
            req1_valid = 1'b0;
            repeat (4) step;
        end
        checks++;
        if (grant_cnt1 !== 16'd3 || grant_cnt0 !== 16'd0)
            begin errors++; $display("FAIL stats_count: got c0=%0d c1=%0d want 0 3", grant_cnt0, grant_cnt1); end
        force dut.grant_cnt0 = 16'hFFFF;
        #1;
        release dut.grant_cnt0;
        req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req0_ready) break;
            step;
        end
        step;
        req0_valid = 1'b0;
        repeat (4) step;
        checks++;
        if (grant_cnt0 !== 16'hFFFF || grant_cnt1 !== 16'd3)
            begin errors++; $display("FAIL stats_saturate: got c0=%h c1=%0d want ffff 3", grant_cnt0, grant_cnt1); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_hold_resp;
        test_reset_mid;
        test_lat3;
`ifdef ALU_ARB_STATS_EN
        test_stats;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
